stack_cmd_sequencer: RTL and testbench
======================================

// Module: stack_cmd_sequencer
// PURPOSE
//  Initiator side of the stack-engine op/apply interface (in, op, apply -> tail, empty, valid).
//  Buffers host commands in a small FIFO and issues them one at a time to the stack engine.
//  Samples the engine response and returns one result per non-PUSH command.
//  Keeps a shadow depth count so it never issues an underflowing POP or an overflowing PUSH.
// PARAMETERS
//  W        8   data width of in/tail/cmd_data/res_data
//  FIFO_D   4   command FIFO depth (power of 2)
//  STK_D    8   stack engine capacity; shadow-count limit
//  ENG_LAT  1   cycles from apply to a valid tail/empty/valid sample (>=1)
// PORTS
//  clk        in   1    clock, rising edge
//  rst        in   1    asynchronous, active-low reset
//  cmd_valid  in   1    host command strobe
//  cmd_ready  out  1    FIFO not full; command accepted when cmd_valid && cmd_ready
//  cmd_op     in   3    opcode: 101 PUSH, 000 POP, others = engine ALU op
//  cmd_data   in   W    PUSH operand (ignored for other ops)
//  op         out  3    to engine
//  in         out  W    to engine
//  apply      out  1    to engine, one-cycle pulse per issued op
//  tail       in   W    engine top-of-stack
//  empty      in   1    engine empty flag
//  valid      in   1    engine result-valid flag
//  res_valid  out  1    one-cycle result strobe
//  res_data   out  W    result: tail sample, or 0 on error
//  res_err    out  1    qualifies res_valid: blocked command or engine !valid
//  depth      out  $clog2(STK_D+1)  shadow stack depth
// BEHAVIOUR
//  Reset (rst=0, async): FIFO empty, cmd_ready=1, state IDLE, op=0, in=0, apply=0,
//   res_valid=0, res_data=0, res_err=0, depth=0. Reset mid-command drops all queued and in-flight work.
//  FIFO: write on cmd_valid&&cmd_ready; pointers wrap modulo FIFO_D; extra count bit separates full/empty.
//   Simultaneous push and pop of a full FIFO is allowed: cmd_ready=0 while full, so only the pop happens.
//  FSM: IDLE -> ISSUE when the FIFO is non-empty. The head entry is popped in the ISSUE cycle.
//   ISSUE: blocked command (POP or ALU op with depth==0, PUSH with depth==STK_D) -> not driven
//     to the engine; go to REPORT with res_err=1, res_data=0.
//   ISSUE otherwise: register op/in and apply=1 for exactly one cycle.
//     PUSH: depth+1, then IDLE. PUSH produces no result.
//     POP: depth-1, then WAIT.
//     ALU op: depth-1 if depth>=2, else unchanged; then WAIT.
//   WAIT: count ENG_LAT cycles after apply, sample tail/valid/empty, go to REPORT.
//   REPORT: res_valid=1 for one cycle; res_data=tail sample; res_err=!valid.
//     If the empty sample disagrees with (depth==0), resync depth to 0 and set res_err=1.
//     Then IDLE.
//  apply is low in every state except the ISSUE cycle, so the engine never sees back-to-back applies.
//  Throughput: PUSH = 2 cycles/cmd (IDLE, ISSUE); others = 3+ENG_LAT cycles.
//  Between issues, op and in hold their last value; the engine ignores them while apply=0.
//  depth saturates at 0 and STK_D and never wraps.
//  cmd_ready is deasserted only on FIFO full, never by FSM state.
// TESTING
//  1. Reset release, then PUSH 1, 2, 9 and POP -> apply pulses 4x with op 101, 101, 101, 000;
//     in = 1, 2, 9; one result res_data=9, res_err=0; depth=2.
//  2. POP with depth==0 after reset -> no apply pulse; res_valid with res_err=1, res_data=0.
//  3. PUSH 4, PUSH 6, op 110 -> result = engine tail (6+4=10 for an ADD engine); depth=1.
//  4. Write 5 commands back-to-back with FIFO_D=4 while the FSM is stalled in WAIT ->
//     cmd_ready=0 after the 4th; the 5th is held; all commands are executed in order.
//  5. Fill the stack with STK_D PUSHes, then one more PUSH -> blocked; res_err=1; depth stays STK_D.
//  6. Assert rst low during WAIT -> all outputs at reset values on the same edge;
//     the FIFO is empty after rst is released.

Source files
------------

// File: rtl/stack_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// stack_cmd_sequencer
//   Initiator for a stack engine's op/apply interface. Host commands are
//   buffered in a small FIFO and issued one at a time. Every command except
//   PUSH returns exactly one result. A shadow depth count stops the sequencer
//   from issuing a POP or ALU op on an empty stack, or a PUSH on a full one.
//
// Ports
//   clk, rst              clock (rising edge), asynchronous active-low reset
//   cmd_valid/cmd_ready   host command handshake (cmd_ready = FIFO not full)
//   cmd_op, cmd_data      opcode (101 PUSH, 000 POP, others ALU) and PUSH operand
//   op, in, apply         engine request; apply is a single-cycle pulse
//   tail, empty, valid    engine response, sampled ENG_LAT cycles after apply
//   res_valid/data/err    one-cycle result strobe, result value, error flag
//   depth                 shadow stack depth
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | wait for a FIFO entry; decide blocked/issue; raise apply
// ISSUE  | apply high; pop FIFO head; update shadow depth
// WAIT   | count engine latency, then sample the engine response
// REPORT | res_valid high for one cycle
// ---------------------------------------------------------------------------
module stack_cmd_sequencer #(
   parameter int W       = 8,
   parameter int FIFO_D  = 4,
   parameter int STK_D   = 8,
   parameter int ENG_LAT = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       cmd_valid,
   output logic                       cmd_ready,
   input  logic [2:0]                 cmd_op,
   input  logic [W-1:0]               cmd_data,
   output logic [2:0]                 op,
   output logic [W-1:0]               in,
   output logic                       apply,
   input  logic [W-1:0]               tail,
   input  logic                       empty,
   input  logic                       valid,
   output logic                       res_valid,
   output logic [W-1:0]               res_data,
   output logic                       res_err,
   output logic [$clog2(STK_D+1)-1:0] depth
);

   localparam int AW = $clog2(FIFO_D);
   localparam int DW = $clog2(STK_D+1);
   localparam int LW = (ENG_LAT > 1) ? $clog2(ENG_LAT) : 1;

   localparam logic [2:0]    OP_PUSH   = 3'b101;
   localparam logic [2:0]    OP_POP    = 3'b000;
   localparam logic [DW-1:0] DEPTH_MAX = DW'(STK_D);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ISSUE  = 2'd1,
      ST_WAIT   = 2'd2,
      ST_REPORT = 2'd3
   } state_t;

   state_t           r_state;
   logic [W+2:0]     r_mem [FIFO_D];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic [2:0]       r_cur_op;
   logic             r_blocked;
   logic [LW-1:0]    r_lat_cnt;
   logic [2:0]       r_op;
   logic [W-1:0]     r_in;
   logic             r_apply;
   logic             r_res_valid;
   logic [W-1:0]     r_res_data;
   logic             r_res_err;
   logic [DW-1:0]    r_depth;

   logic             w_full;
   logic             w_empty;
   logic             w_push;
   logic             w_pop;
   logic [W+2:0]     w_head;
   logic [2:0]       w_head_op;
   logic [W-1:0]     w_head_data;
   logic             w_head_blocked;

   // Extra pointer bit: equal low bits with differing MSB means full.
   assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_empty   = (r_wr_ptr == r_rd_ptr);
   assign w_push    = cmd_valid && !w_full;
   assign w_pop     = (r_state == ST_ISSUE);
   assign cmd_ready = !w_full;

   assign w_head      = r_mem[r_rd_ptr[AW-1:0]];
   assign w_head_op   = w_head[W+2:W];
   assign w_head_data = w_head[W-1:0];

   // POP and ALU ops both need at least one operand on the stack.
   assign w_head_blocked = (w_head_op == OP_PUSH) ? (r_depth == DEPTH_MAX)
                                                  : (r_depth == '0);

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr[AW-1:0]] <= {cmd_op, cmd_data};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   // The issue decision is taken in IDLE so that apply, op and in are
   // registered and apply is high exactly during the ISSUE cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= ST_IDLE;
         r_cur_op    <= '0;
         r_blocked   <= 1'b0;
         r_lat_cnt   <= '0;
         r_op        <= '0;
         r_in        <= '0;
         r_apply     <= 1'b0;
         r_res_valid <= 1'b0;
         r_res_data  <= '0;
         r_res_err   <= 1'b0;
         r_depth     <= '0;
      end else begin
         r_apply     <= 1'b0;
         r_res_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (!w_empty) begin
                  r_state   <= ST_ISSUE;
                  r_cur_op  <= w_head_op;
                  r_blocked <= w_head_blocked;
                  if (!w_head_blocked) begin
                     r_apply <= 1'b1;
                     r_op    <= w_head_op;
                     if (w_head_op == OP_PUSH) r_in <= w_head_data;
                  end
               end
            end
            ST_ISSUE: begin
               if (r_blocked) begin
                  r_state     <= ST_REPORT;
                  r_res_valid <= 1'b1;
                  r_res_data  <= '0;
                  r_res_err   <= 1'b1;
               end else if (r_cur_op == OP_PUSH) begin
                  r_depth <= r_depth + DW'(1);
                  r_state <= ST_IDLE;
               end else begin
                  if (r_cur_op == OP_POP || r_depth >= DW'(2)) begin
                     r_depth <= r_depth - DW'(1);
                  end
                  r_lat_cnt <= LW'(ENG_LAT - 1);
                  r_state   <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (r_lat_cnt == '0) begin
                  r_state     <= ST_REPORT;
                  r_res_valid <= 1'b1;
                  r_res_data  <= tail;
                  // Engine and shadow count disagree: trust the engine.
                  if (empty != (r_depth == '0)) begin
                     r_depth   <= '0;
                     r_res_err <= 1'b1;
                  end else begin
                     r_res_err <= !valid;
                  end
               end else begin
                  r_lat_cnt <= r_lat_cnt - LW'(1);
               end
            end
            ST_REPORT: begin
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign op        = r_op;
   assign in        = r_in;
   assign apply     = r_apply;
   assign res_valid = r_res_valid;
   assign res_data  = r_res_data;
   assign res_err   = r_res_err;
   assign depth     = r_depth;

endmodule

// File: tb/tb_stack_cmd_sequencer.sv
module tb_stack_cmd_sequencer;
   localparam int W       = 8;
   localparam int FIFO_D  = 4;
   localparam int STK_D   = 8;
   localparam int ENG_LAT = 4;
   localparam int DW      = $clog2(STK_D+1);

   localparam logic [2:0] OP_PUSH = 3'b101;
   localparam logic [2:0] OP_POP  = 3'b000;
   localparam logic [2:0] OP_ADD  = 3'b110;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [2:0]    cmd_op = '0;
   logic [W-1:0]  cmd_data = '0;
   logic [2:0]    op;
   logic [W-1:0]  in;
   logic          apply;
   logic [W-1:0]  tail;
   logic          empty;
   logic          valid;
   logic          res_valid;
   logic [W-1:0]  res_data;
   logic          res_err;
   logic [DW-1:0] depth;

   int n_checks = 0;
   int n_fail   = 0;
   int n_apply  = 0;
   int n_res    = 0;
   logic [W-1:0] last_res_data = '0;
   logic         last_res_err  = 1'b0;
   logic         prev_apply    = 1'b0;

   logic [W+2:0] q_app [$];
   logic [W:0]   q_res [$];
   logic [W-1:0] mdl_stk [$];
   logic [W-1:0] mdl_tail = '0;

   always #5 clk = ~clk;

   stack_cmd_sequencer #(.W(W), .FIFO_D(FIFO_D), .STK_D(STK_D), .ENG_LAT(ENG_LAT)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_data(cmd_data), .op(op), .in(in), .apply(apply),
      .tail(tail), .empty(empty), .valid(valid), .res_valid(res_valid),
      .res_data(res_data), .res_err(res_err), .depth(depth)
   );

   function automatic logic [W-1:0] alu(input logic [2:0] o, input logic [W-1:0] a,
                                        input logic [W-1:0] b);
      case (o)
         3'b111:  return b - a;
         3'b001:  return a & b;
         3'b010:  return a | b;
         3'b011:  return a ^ b;
         default: return a + b;
      endcase
   endfunction

   // Stack engine: outputs appear exactly ENG_LAT cycles after apply.
   logic [W-1:0] e_stk [32];
   int           e_cnt;
   logic [W-1:0] e_a, e_b, e_t, e_last;
   logic         e_v;
   logic [W-1:0] s_tail  [ENG_LAT];
   logic         s_empty [ENG_LAT];
   logic         s_valid [ENG_LAT];
   assign tail  = s_tail[ENG_LAT-1];
   assign empty = s_empty[ENG_LAT-1];
   assign valid = s_valid[ENG_LAT-1];

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         e_cnt  = 0;
         e_last = '0;
         for (int i = 0; i < ENG_LAT; i++) begin
            s_tail[i]  <= '0;
            s_empty[i] <= 1'b1;
            s_valid[i] <= 1'b0;
         end
      end else begin
         for (int i = 1; i < ENG_LAT; i++) begin
            s_tail[i]  <= s_tail[i-1];
            s_empty[i] <= s_empty[i-1];
            s_valid[i] <= s_valid[i-1];
         end
         if (apply) begin
            e_v = 1'b0;
            e_t = e_last;
            if (op == OP_PUSH) begin
               e_stk[e_cnt] = in; e_cnt++; e_t = in; e_v = 1'b1;
            end else if (op == OP_POP) begin
               if (e_cnt > 0) begin e_cnt--; e_t = e_stk[e_cnt]; e_v = 1'b1; end
            end else if (e_cnt >= 2) begin
               e_a = e_stk[e_cnt-1]; e_b = e_stk[e_cnt-2];
               e_t = alu(op, e_a, e_b);
               e_cnt = e_cnt - 1; e_stk[e_cnt-1] = e_t; e_v = 1'b1;
            end
            e_last = e_t;
            s_tail[0]  <= e_t;
            s_empty[0] <= (e_cnt == 0);
            s_valid[0] <= e_v;
         end
      end
   end

   // Monitor: checks every apply pulse and every result against the scoreboard.
   always @(negedge clk) begin
      if (!rst) begin
         prev_apply = 1'b0;
      end else begin
         if (apply) begin
            n_apply++;
            n_checks++;
            if (prev_apply) begin
               n_fail++;
               $display("FAIL apply_b2b: apply high on consecutive cycles, required one-cycle pulses");
            end
            n_checks++;
            if (q_app.size() == 0) begin
               n_fail++;
               $display("FAIL apply_unexpected: op=%b in=%0d, required no apply", op, in);
            end else begin
               logic [W+2:0] ea;
               ea = q_app.pop_front();
               if (op !== ea[W+2:W] || (ea[W+2:W] == OP_PUSH && in !== ea[W-1:0])) begin
                  n_fail++;
                  $display("FAIL apply_cmd: op=%b in=%0d, required op=%b in=%0d",
                           op, in, ea[W+2:W], ea[W-1:0]);
               end
            end
         end
         prev_apply = apply;
         if (res_valid) begin
            n_res++;
            last_res_data = res_data;
            last_res_err  = res_err;
            n_checks++;
            if (q_res.size() == 0) begin
               n_fail++;
               $display("FAIL res_unexpected: data=%0d err=%b, required no result", res_data, res_err);
            end else begin
               logic [W:0] er;
               er = q_res.pop_front();
               if ({res_err, res_data} !== er) begin
                  n_fail++;
                  $display("FAIL res_value: data=%0d err=%b, required data=%0d err=%b",
                           res_data, res_err, er[W-1:0], er[W]);
               end
            end
         end
      end
   end

   task automatic model_cmd(input logic [2:0] o, input logic [W-1:0] d);
      logic [W-1:0] a, b, r;
      if (o == OP_PUSH) begin
         if (mdl_stk.size() == STK_D) q_res.push_back({1'b1, {W{1'b0}}});
         else begin
            mdl_stk.push_back(d); mdl_tail = d; q_app.push_back({o, d});
         end
      end else if (mdl_stk.size() == 0) begin
         q_res.push_back({1'b1, {W{1'b0}}});
      end else begin
         q_app.push_back({o, d});
         if (o == OP_POP) begin
            a = mdl_stk.pop_back(); mdl_tail = a; q_res.push_back({1'b0, a});
         end else if (mdl_stk.size() == 1) begin
            q_res.push_back({1'b1, mdl_tail});
         end else begin
            a = mdl_stk.pop_back(); b = mdl_stk.pop_back();
            r = alu(o, a, b); mdl_stk.push_back(r); mdl_tail = r;
            q_res.push_back({1'b0, r});
         end
      end
   endtask

   // Called and returns on a falling edge.
   task automatic send(input logic [2:0] o, input logic [W-1:0] d, output int waited);
      waited = 0;
      model_cmd(o, d);
      cmd_op = o; cmd_data = d; cmd_valid = 1'b1;
      while (!cmd_ready && waited < 300) begin
         @(negedge clk); waited++;
      end
      if (!cmd_ready) begin
         n_checks++; n_fail++;
         $display("FAIL send_timeout: cmd_ready=%b after %0d cycles, required 1", cmd_ready, waited);
         cmd_valid = 1'b0;
         return;
      end
      @(posedge clk); #1 cmd_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic wait_drain();
      int c = 0;
      while ((q_app.size() != 0 || q_res.size() != 0) && c < 1000) begin
         @(negedge clk); c++;
      end
      n_checks++;
      if (q_app.size() != 0 || q_res.size() != 0) begin
         n_fail++;
         $display("FAIL drain_timeout: %0d applies %0d results outstanding, required 0",
                  q_app.size(), q_res.size());
         q_app.delete(); q_res.delete();
      end
      repeat (4) @(negedge clk);
   endtask

   task automatic check_depth(input string name);
      n_checks++;
      if (depth !== DW'(mdl_stk.size())) begin
         n_fail++;
         $display("FAIL %s: depth=%0d, required %0d", name, depth, mdl_stk.size());
      end
   endtask

   task automatic check_reset_outputs(input string name);
      n_checks++;
      if (cmd_ready !== 1'b1 || apply !== 1'b0 || op !== 3'b0 || in !== '0 ||
          res_valid !== 1'b0 || res_data !== '0 || res_err !== 1'b0 || depth !== '0) begin
         n_fail++;
         $display("FAIL %s: ready=%b apply=%b op=%b in=%0d rv=%b rd=%0d re=%b depth=%0d, required 1 0 000 0 0 0 0 0",
                  name, cmd_ready, apply, op, in, res_valid, res_data, res_err, depth);
      end
   endtask

   task automatic do_reset();
      cmd_valid = 1'b0;
      rst = 1'b0;
      q_app.delete(); q_res.delete(); mdl_stk.delete(); mdl_tail = '0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_outputs("reset_values");
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_reset_outputs("idle_after_release");
   endtask

   task automatic test_push_pop();
      int w, a0, r0;
      do_reset();
      a0 = n_apply; r0 = n_res;
      send(OP_PUSH, 8'd1, w);
      send(OP_PUSH, 8'd2, w);
      send(OP_PUSH, 8'd9, w);
      send(OP_POP,  8'd0, w);
      wait_drain();
      n_checks++;
      if (n_apply - a0 != 4) begin
         n_fail++; $display("FAIL pp_apply_count: %0d, required 4", n_apply - a0);
      end
      n_checks++;
      if (n_res - r0 != 1 || last_res_data !== 8'd9 || last_res_err !== 1'b0) begin
         n_fail++;
         $display("FAIL pp_result: count=%0d data=%0d err=%b, required 1 9 0",
                  n_res - r0, last_res_data, last_res_err);
      end
      check_depth("pp_depth");
   endtask

   task automatic test_pop_empty();
      int w, a0, r0;
      do_reset();
      a0 = n_apply; r0 = n_res;
      send(OP_POP, 8'd0, w);
      wait_drain();
      n_checks++;
      if (n_apply != a0 || n_res - r0 != 1 || last_res_err !== 1'b1 || last_res_data !== '0) begin
         n_fail++;
         $display("FAIL pop_empty: applies=%0d results=%0d data=%0d err=%b, required 0 1 0 1",
                  n_apply - a0, n_res - r0, last_res_data, last_res_err);
      end
      check_depth("pop_empty_depth");
   endtask

   task automatic test_alu();
      int w;
      do_reset();
      send(OP_PUSH, 8'd4, w);
      send(OP_PUSH, 8'd6, w);
      send(OP_ADD,  8'd0, w);
      wait_drain();
      n_checks++;
      if (last_res_data !== 8'd10 || last_res_err !== 1'b0) begin
         n_fail++;
         $display("FAIL alu_add: data=%0d err=%b, required 10 0", last_res_data, last_res_err);
      end
      check_depth("alu_depth");
      // Binary op with a single operand: issued, engine reports !valid.
      send(OP_ADD, 8'd0, w);
      wait_drain();
      n_checks++;
      if (last_res_err !== 1'b1 || depth !== DW'(1)) begin
         n_fail++;
         $display("FAIL alu_single: err=%b depth=%0d, required 1 1", last_res_err, depth);
      end
   endtask

   task automatic test_back_to_back();
      int w, c;
      do_reset();
      for (int i = 1; i <= 5; i++) send(OP_PUSH, W'(i * 10), w);
      wait_drain();
      send(OP_POP, 8'd0, w);
      c = 0;
      while (!apply && c < 50) begin @(negedge clk); c++; end
      n_checks++;
      if (!apply) begin
         n_fail++; $display("FAIL b2b_apply_timeout: apply=%b, required 1", apply);
      end
      send(OP_PUSH, 8'd60, w);
      send(OP_POP,  8'd0,  w);
      send(OP_ADD,  8'd0,  w);
      send(OP_POP,  8'd0,  w);
      n_checks++;
      if (cmd_ready !== 1'b0) begin
         n_fail++; $display("FAIL b2b_full: cmd_ready=%b, required 0", cmd_ready);
      end
      send(OP_POP, 8'd0, w);
      n_checks++;
      if (w == 0) begin
         n_fail++; $display("FAIL b2b_held: fifth command waited %0d cycles, required >0", w);
      end
      wait_drain();
      check_depth("b2b_depth");
   endtask

   task automatic test_overflow();
      int w, a0;
      do_reset();
      for (int i = 0; i < STK_D; i++) send(OP_PUSH, W'(i * 3 + 1), w);
      wait_drain();
      check_depth("ovf_full_depth");
      a0 = n_apply;
      send(OP_PUSH, 8'd99, w);
      wait_drain();
      n_checks++;
      if (n_apply != a0 || last_res_err !== 1'b1 || last_res_data !== '0 || depth !== DW'(STK_D)) begin
         n_fail++;
         $display("FAIL ovf_blocked: applies=%0d err=%b data=%0d depth=%0d, required 0 1 0 %0d",
                  n_apply - a0, last_res_err, last_res_data, depth, STK_D);
      end
   endtask

   task automatic test_reset_in_wait();
      int w, c, a0, r0;
      do_reset();
      send(OP_PUSH, 8'd7, w);
      send(OP_POP,  8'd0, w);
      send(OP_PUSH, 8'd3, w);
      c = 0;
      while (!(apply && op == OP_POP) && c < 50) begin @(negedge clk); c++; end
      n_checks++;
      if (!(apply && op == OP_POP)) begin
         n_fail++; $display("FAIL rw_apply_timeout: apply=%b op=%b, required 1 000", apply, op);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_reset_outputs("rw_async_reset");
      q_app.delete(); q_res.delete(); mdl_stk.delete(); mdl_tail = '0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      a0 = n_apply; r0 = n_res;
      repeat (20) @(negedge clk);
      n_checks++;
      if (n_apply != a0 || n_res != r0 || cmd_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL rw_fifo_flushed: applies=%0d results=%0d ready=%b, required 0 0 1",
                  n_apply - a0, n_res - r0, cmd_ready);
      end
      send(OP_POP, 8'd0, w);
      wait_drain();
      n_checks++;
      if (last_res_err !== 1'b1 || depth !== '0) begin
         n_fail++;
         $display("FAIL rw_depth_cleared: err=%b depth=%0d, required 1 0", last_res_err, depth);
      end
   endtask

   initial begin
      test_reset();
      test_push_pop();
      test_pop_empty();
      test_alu();
      test_back_to_back();
      test_overflow();
      test_reset_in_wait();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
